game_status_ctrl: RTL
=====================

// Module: game_status_ctrl
// PURPOSE
//  Game-flow controller producing the one-hot 4-bit status bus consumed by the screen renderers,
//  including gameover (4'b1000 = game-over page). Consumes per-pixel-derived hazard flags
//  (is_dead_boy / is_dead_girl), door-reached flags and keyboard keycode. Debounces death over
//  frames, enforces a minimum game-over display time and pulses level_reset to respawn characters.
// PARAMETERS
//  DEATH_FRAMES   2      consecutive frame ticks with a death flag needed to end the game (>=1)
//  GAMEOVER_HOLD  60     frame ticks the GAMEOVER/WIN page is held before keys are accepted
//  START_KEY      8'h28  keycode (Enter) that starts / restarts the game
//  CNT_W          6      width of frame counters; must hold max(DEATH_FRAMES, GAMEOVER_HOLD)
// PORTS
//  Clk           in   1  system clock
//  Reset         in   1  synchronous, active-high reset
//  frame_clk     in   1  vertical-sync rate frame clock (asynchronous to Clk)
//  keycode       in   8  current keyboard keycode, 8'h00 = no key
//  is_dead_boy   in   1  boy foot samples touch water/acid
//  is_dead_girl  in   1  girl foot samples touch lava/acid
//  boy_at_door   in   1  boy inside his exit door
//  girl_at_door  in   1  girl inside her exit door
//  status        out  4  4'b0001 START, 4'b0010 PLAY, 4'b0100 WIN, 4'b1000 GAMEOVER
//  level_reset   out  1  one-Clk pulse: respawn characters / reload level
//  dead_who      out  2  {boy,girl} which character(s) caused game over; 00 otherwise
// BEHAVIOUR
//  - Reset (sync, highest priority, any state): status=0001, level_reset=0, dead_who=00,
//    death_cnt=0, hold_cnt=0, sync flops=0, key_prev=00.
//  - frame_tick: frame_clk through 2-flop synchronizer, rising edge of synced value -> 1-Clk
//    pulse; latency 3 Clk from frame_clk rise. All counters advance only on frame_tick.
//  - key_hit: keycode==START_KEY this cycle and key_prev!=START_KEY (key_prev = last cycle's
//    keycode, registered). Holding the key gives exactly one key_hit.
//  - START: key_hit -> PLAY. No hold time in START.
//  - PLAY entry (from START or GAMEOVER): level_reset=1 for exactly the first Clk cycle with
//    status==PLAY; death_cnt=0, dead_who=00 on entry.
//  - PLAY, on frame_tick only (flags ignored between ticks):
//      dead = is_dead_boy|is_dead_girl. dead: death_cnt+1, dead_who |= {boy,girl};
//      !dead: death_cnt=0, dead_who=00.
//      death_cnt+1 == DEATH_FRAMES -> GAMEOVER next cycle, dead_who frozen, hold_cnt=0.
//      else boy_at_door & girl_at_door & !dead -> WIN, hold_cnt=0.
//      Death reaching threshold and win on same tick: GAMEOVER wins. Door flags with any death
//      flag on that tick: no WIN.
//  - GAMEOVER: hold_cnt +1 per frame_tick, saturating at GAMEOVER_HOLD. key_hit while
//    hold_cnt<GAMEOVER_HOLD ignored (not queued). key_hit with hold_cnt==GAMEOVER_HOLD -> PLAY
//    (restart, level_reset pulse, dead_who cleared).
//  - WIN: same hold rule; accepted key_hit -> START, dead_who stays 00.
//  - keycode in PLAY has no effect on state. level_reset never asserted outside PLAY entry.
//  - All outputs registered; status is always exactly one-hot; illegal state -> START.
//  - Reset mid-game: status=0001 next cycle, no level_reset pulse, pending counts discarded.
// TESTING
//  1 Reset 3 cyc -> status=0001, level_reset=0, dead_who=00; keycode=28 held 10 cyc -> one
//    transition to 0010, level_reset high exactly 1 cyc.
//  2 PLAY, is_dead_girl=1 across 2 frame ticks -> status=1000 1 cyc after 2nd tick, dead_who=01;
//    death flag on 1 tick then clear on next -> stays 0010.
//  3 PLAY, death pulse high only between frame ticks (never at tick) -> no state change.
//  4 GAMEOVER: keycode=28 pressed after 30 ticks -> stays 1000; released, pressed after
//    tick 60 -> 0010, level_reset pulse, dead_who=00.
//  5 PLAY, both door flags=1 with is_dead_boy=1 on 2nd consecutive death tick -> 1000,
//    dead_who=10; same doors no death -> 0100; after 60 ticks keycode=28 -> 0001.
//  6 Assert Reset in GAMEOVER with hold_cnt=40 -> 0001 next cycle; Reset held while
//    keycode=28 -> stays 0001.

Source files
------------

// File: rtl/game_status_if.sv
// Signal bundle between the game-flow controller and the rest of the game:
// hazard/door/key inputs toward the controller, status/respawn outputs back.
interface game_status_if;
    logic [7:0] keycode;
    logic       is_dead_boy;
    logic       is_dead_girl;
    logic       boy_at_door;
    logic       girl_at_door;
    logic [3:0] status;
    logic       level_reset;
    logic [1:0] dead_who;

    modport master (
        output keycode, is_dead_boy, is_dead_girl, boy_at_door, girl_at_door,
        input  status, level_reset, dead_who
    );

    modport slave (
        input  keycode, is_dead_boy, is_dead_girl, boy_at_door, girl_at_door,
        output status, level_reset, dead_who
    );
endinterface

// File: rtl/game_status_ctrl.sv
// Game-flow controller: START/PLAY/WIN/GAMEOVER one-hot status, frame-debounced death,
// minimum hold on end pages and a one-cycle level_reset pulse on every PLAY entry.
module game_status_ctrl #(
    parameter int unsigned DEATH_FRAMES  = 2,
    parameter int unsigned GAMEOVER_HOLD = 60,
    parameter logic [7:0]  START_KEY     = 8'h28,
    parameter int unsigned CNT_W         = 6
) (
    input logic         Clk,
    input logic         Reset,
    input logic         frame_clk,
    game_status_if.slave gs
);

    typedef enum logic [3:0] {
        StStart    = 4'b0001,
        StPlay     = 4'b0010,
        StWin      = 4'b0100,
        StGameover = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   death_cnt_q, death_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]         dead_who_q, dead_who_d;
    logic               level_reset_q, level_reset_d;
    logic [7:0]         key_prev_q;
    // [0],[1]: synchronizer; [2]: previous synced value for edge detect
    logic [2:0]         fsync_q;

    logic             frame_tick;
    logic             key_hit;
    logic             dead;
    logic             hold_done;
    logic [CNT_W-1:0] death_inc;

    assign frame_tick = fsync_q[1] & ~fsync_q[2];
    assign key_hit    = (gs.keycode == START_KEY) && (key_prev_q != START_KEY);
    assign dead       = gs.is_dead_boy | gs.is_dead_girl;
    assign hold_done  = (hold_cnt_q == CNT_W'(GAMEOVER_HOLD));
    assign death_inc  = death_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        death_cnt_d   = death_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        dead_who_d    = dead_who_q;
        level_reset_d = 1'b0;
        case (state_q)
            StStart: begin
                if (key_hit) begin
                    state_d       = StPlay;
                    level_reset_d = 1'b1;
                    death_cnt_d   = '0;
                    dead_who_d    = 2'b00;
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (dead) begin
                        death_cnt_d = death_inc;
                        dead_who_d  = dead_who_q | {gs.is_dead_boy, gs.is_dead_girl};
                        if (death_inc == CNT_W'(DEATH_FRAMES)) begin
                            state_d    = StGameover;
                            hold_cnt_d = '0;
                        end
                    end else begin
                        death_cnt_d = '0;
                        dead_who_d  = 2'b00;
                        if (gs.boy_at_door && gs.girl_at_door) begin
                            state_d    = StWin;
                            hold_cnt_d = '0;
                        end
                    end
                end
            end
            StWin, StGameover: begin
                // Keys pressed before the hold expires are dropped, not queued
                if (key_hit && hold_done) begin
                    dead_who_d  = 2'b00;
                    death_cnt_d = '0;
                    if (state_q == StGameover) begin
                        state_d       = StPlay;
                        level_reset_d = 1'b1;
                    end else begin
                        state_d = StStart;
                    end
                end else if (frame_tick && !hold_done) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = StStart;
                death_cnt_d = '0;
                hold_cnt_d  = '0;
                dead_who_d  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StStart;
            death_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            dead_who_q    <= 2'b00;
            level_reset_q <= 1'b0;
            key_prev_q    <= 8'h00;
            fsync_q       <= 3'b000;
        end else begin
            state_q       <= state_d;
            death_cnt_q   <= death_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            dead_who_q    <= dead_who_d;
            level_reset_q <= level_reset_d;
            key_prev_q    <= gs.keycode;
            fsync_q       <= {fsync_q[1:0], frame_clk};
        end
    end

    assign gs.status      = state_q;
    assign gs.level_reset = level_reset_q;
    assign gs.dead_who    = dead_who_q;

endmodule
